// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory req/gnt/rvalid bus between fetch unit and memory
interface if_fetch_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) ();
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_gnt;
    logic                  imem_rvalid;
    logic [INST_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: single-outstanding fetch, bubbles, stall hold buffer, redirect flush
// Optional perf counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    if_fetch_unit_if.master       imem,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic                  kill_q, kill_d;
    logic                  hold_valid_q;
    logic [PC_WIDTH-1:0]   hold_pc_q;
    logic [INST_WIDTH-1:0] hold_inst_q;

    logic granted, rsp_ok, outstanding, hold_next_full;

    assign granted        = (state_q == S_REQ) && imem.imem_gnt;
    assign rsp_ok         = imem.imem_rvalid && !kill_q;
    assign outstanding    = ((state_q == S_WAIT) && !imem.imem_rvalid) || granted;
    // Buffer is occupied next cycle only while the stall persists without a flush
    assign hold_next_full = stall_i && !redirect_i && (hold_valid_q || rsp_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = granted ? fetch_pc_q : resp_pc_q;
        kill_d     = imem.imem_rvalid ? 1'b0 : kill_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: if (imem.imem_gnt) begin
                state_d    = S_WAIT;
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            end
            S_WAIT: if (imem.imem_rvalid) state_d = hold_next_full ? S_HOLD : S_REQ;
            S_HOLD: if (!hold_next_full) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        // A still-pending response must be drained (and discarded) before refetching
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~PC_WIDTH'(3);
            kill_d     = outstanding;
            state_d    = outstanding ? S_WAIT : S_REQ;
        end
    end

    always_comb begin
        imem.imem_req  = (state_q == S_REQ);
        imem.imem_addr = fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o         <= '0;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= NOP_INST;
        end else if (redirect_i) begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (stall_i) begin
            if (rsp_ok) begin
                hold_valid_q <= 1'b1;
                hold_pc_q    <= resp_pc_q;
                hold_inst_q  <= imem.imem_rdata;
            end
        end else if (hold_valid_q) begin
            pc_o         <= hold_pc_q;
            inst_o       <= hold_inst_q;
            inst_valid_o <= 1'b1;
            hold_valid_q <= 1'b0;
        end else if (rsp_ok) begin
            pc_o         <= resp_pc_q;
            inst_o       <= imem.imem_rdata;
            inst_valid_o <= 1'b1;
        end else begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end
    end

`ifdef IF_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (rsp_ok && !redirect_i) perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
            if (stall_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed + randomized bench for if_fetch_unit with in-order stream model
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc, inst;
    logic        inst_valid;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    always #5 clk = ~clk;

    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem(bus.master),
        .pc_o(pc), .inst_o(inst), .inst_valid_o(inst_valid)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetch_cnt_o(perf_fetch), .perf_stall_cnt_o(perf_stall)
`endif
    );

    int n_pass = 0, n_total = 0, n_valid = 0;
    int gnt_pct, lat_lo, lat_hi;
    logic        pend, stale;
    logic [31:0] pend_addr;
    int          cnt;
    logic [31:0] exp_pc, prev_pc, prev_inst;
    logic        prev_valid;
    int          m_fetch, m_stall;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h8) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        logic g, rv;
        logic [31:0] ga;
        g  = !rst && bus.imem_req && ($urandom_range(99) < gnt_pct);
        rv = !rst && pend && (cnt == 0);
        if (!rst && bus.imem_req) begin
            chk("single_outstanding", {31'd0, pend}, 32'd0);
            chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
        end
        ga = bus.imem_addr;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? memf(pend_addr) : $urandom;
        prev_pc = pc; prev_inst = inst; prev_valid = inst_valid;
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0; exp_pc = 32'h0; m_fetch = 0; m_stall = 0;
            chk("rst_pc", pc, 32'h0);
            chk("rst_inst", inst, NOP);
            chk("rst_valid", {31'd0, inst_valid}, 32'd0);
            chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        end else begin
            if (rv && !stale && !redirect) m_fetch++;
            if (stall) m_stall++;
            if (rv) pend = 1'b0;
            else if (pend) cnt--;
            if (g) begin
                pend = 1'b1; pend_addr = ga; stale = 1'b0;
                cnt = $urandom_range(lat_hi, lat_lo) - 1;
            end
            if (redirect && pend) stale = 1'b1;
            if (redirect) begin
                chk("redir_inst", inst, NOP);
                chk("redir_valid", {31'd0, inst_valid}, 32'd0);
                exp_pc = redirect_pc & ~32'd3;
            end else if (stall) begin
                chk("stall_pc", pc, prev_pc);
                chk("stall_inst", inst, prev_inst);
                chk("stall_valid", {31'd0, inst_valid}, {31'd0, prev_valid});
            end else if (inst_valid) begin
                chk("stream_pc", pc, exp_pc);
                chk("stream_inst", inst, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_valid++;
            end else begin
                chk("bubble_pc", pc, prev_pc);
                chk("bubble_inst", inst, NOP);
            end
        end
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!bus.imem_req && k < 20) begin tick(); k++; end
        chk({tag, "_req_timeout"}, {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!inst_valid && k < 20) begin tick(); k++; end
        chk({tag, "_valid_timeout"}, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        pend = 1'b0; stale = 1'b0; pend_addr = '0; cnt = 0;
        exp_pc = '0; m_fetch = 0; m_stall = 0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        tick(); tick();

        rst = 1'b0;
        tick();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        tick();
        chk("wait_no_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        chk("first_pc", pc, 32'h0);
        chk("first_inst", inst, 32'h0050_0093);
        chk("first_valid", {31'd0, inst_valid}, 32'd1);
        chk("second_addr", bus.imem_addr, 32'h4);
        tick();
        chk("alt_bubble", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("second_pc", pc, 32'h4);
        tick();

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("hold_pc", pc, 32'h8);
        chk("hold_inst", inst, 32'hDEAD_BEEF);
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("after_hold_addr", bus.imem_addr, 32'hC);

        lat_lo = 3; lat_hi = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0; lat_lo = 1; lat_hi = 1;
        wait_req("redir");
        chk("redir_addr", bus.imem_addr, 32'h100);
        wait_valid("redir");
        chk("redir_first_pc", pc, 32'h100);

        wait_req("hold_redir");
        stall = 1'b1;
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("hr_inst", inst, NOP);
        chk("hr_valid", {31'd0, inst_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b0;
        wait_valid("hold_redir");
        chk("hr_pc", pc, 32'h200);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        wait_req("wrap");
        chk("wrap_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        wait_req("wrap2");
        chk("wrap_addr_lo", bus.imem_addr, 32'h0);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch_dir", perf_fetch, m_fetch);
        chk("perf_stall_dir", perf_stall, m_stall);
`endif

        gnt_pct = 60; lat_lo = 1; lat_hi = 4;
        n_valid = 0;
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(3) == 0);
            redirect = ($urandom_range(19) == 0);
            redirect_pc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(7)))
                                                   : 32'($urandom);
            rst = (i == 1500);
            tick();
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        chk("progress", {31'd0, (n_valid > 100)}, 32'd1);
`ifdef IF_FETCH_PERF_EN
        chk("perf_fetch_rand", perf_fetch, m_fetch);
        chk("perf_stall_rand", perf_stall, m_stall);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
